// File: rtl/multi_channel_timer.sv
// -----------------------------------------------------------------------------
// multi_channel_timer
//
// NUM_CH independent down-counting timers sharing one configuration port.
// Each channel keeps a shadow period/mode, which software writes at any time,
// and an active period/mode, which governs the interval currently being timed.
// The shadow is copied to the active copy on start and on every periodic
// reload, so a write never disturbs an interval that is already in progress.
//
// Ports:
//   clk          sole clock, rising edge
//   reset        synchronous, active-high; clears every channel
//   cfg_we       shadow write strobe
//   cfg_ch       channel addressed by cfg_we (indices >= NUM_CH are ignored)
//   cfg_period   tick interval in clk cycles (0 behaves as 1)
//   cfg_oneshot  1 = one-shot, 0 = periodic
//   start[i]     load shadow into channel i and (re)start it
//   stop[i]      abort channel i; wins over a same-cycle start[i]
//   pause        freezes all counters and FSMs; strobes still act
//   tick[i]      one-cycle pulse per expiry (registered)
//   active[i]    channel i is in RUN (registered)
//   done[i]      sticky one-shot completion flag (registered)
//
// Control inputs are level-sampled strobes; there is no valid/ready
// handshake: every input is acted on at the edge where it is high.
// Per-channel FSM state is held in ch_state for probing by checkers.
// -----------------------------------------------------------------------------
module multi_channel_timer #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 26,
    parameter int CH_W   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [WIDTH-1:0]  cfg_period,
    input  logic              cfg_oneshot,
    input  logic [NUM_CH-1:0] start,
    input  logic [NUM_CH-1:0] stop,
    input  logic              pause,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] active,
    output logic [NUM_CH-1:0] done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            ch_state   [NUM_CH];
    state_t            state_d    [NUM_CH];
    logic [WIDTH-1:0]  cnt_q      [NUM_CH];
    logic [WIDTH-1:0]  cnt_d      [NUM_CH];
    logic [WIDTH-1:0]  shd_per_q  [NUM_CH];
    logic [WIDTH-1:0]  shd_per_d  [NUM_CH];
    logic [WIDTH-1:0]  act_per_q  [NUM_CH];
    logic [WIDTH-1:0]  act_per_d  [NUM_CH];
    logic [NUM_CH-1:0] shd_mode_q;
    logic [NUM_CH-1:0] shd_mode_d;
    logic [NUM_CH-1:0] act_mode_q;
    logic [NUM_CH-1:0] act_mode_d;
    logic [NUM_CH-1:0] wr_hit;
    logic [NUM_CH-1:0] tick_d;
    logic [NUM_CH-1:0] active_d;
    logic [NUM_CH-1:0] done_d;

    // Counter load value: a period of 0 is treated as 1, so both load 0.
    function automatic logic [WIDTH-1:0] load_value(input logic [WIDTH-1:0] p);
        return (p == '0) ? '0 : p - WIDTH'(1);
    endfunction

    // Channel decode; an out-of-range cfg_ch simply matches no channel.
    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_hit[i] = cfg_we && (cfg_ch == CH_W'(i));
        end
    end

    // Next-state logic for every channel.
    always_comb begin
        tick_d     = '0;
        active_d   = '0;
        done_d     = '0;
        shd_mode_d = shd_mode_q;
        act_mode_d = act_mode_q;
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i]   = ch_state[i];
            cnt_d[i]     = cnt_q[i];
            shd_per_d[i] = shd_per_q[i];
            act_per_d[i] = act_per_q[i];

            if (wr_hit[i]) begin
                shd_per_d[i]  = cfg_period;
                shd_mode_d[i] = cfg_oneshot;
            end

            // Start and reload use shd_*_d so a same-edge shadow write is seen.
            if (stop[i]) begin
                state_d[i] = ST_IDLE;
                cnt_d[i]   = '0;
            end else if (start[i]) begin
                state_d[i]    = ST_RUN;
                act_per_d[i]  = shd_per_d[i];
                act_mode_d[i] = shd_mode_d[i];
                cnt_d[i]      = load_value(shd_per_d[i]);
            end else if (ch_state[i] == ST_RUN && !pause) begin
                if (cnt_q[i] != '0) begin
                    cnt_d[i] = cnt_q[i] - WIDTH'(1);
                end else begin
                    tick_d[i] = 1'b1;
                    if (act_mode_q[i]) begin
                        state_d[i] = ST_DONE;
                    end else begin
                        act_per_d[i]  = shd_per_d[i];
                        act_mode_d[i] = shd_mode_d[i];
                        cnt_d[i]      = load_value(shd_per_d[i]);
                    end
                end
            end

            active_d[i] = (state_d[i] == ST_RUN);
            done_d[i]   = (state_d[i] == ST_DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                ch_state[i]  <= ST_IDLE;
                cnt_q[i]     <= '0;
                shd_per_q[i] <= '0;
                act_per_q[i] <= '0;
            end
            shd_mode_q <= '0;
            act_mode_q <= '0;
            tick       <= '0;
            active     <= '0;
            done       <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                ch_state[i]  <= state_d[i];
                cnt_q[i]     <= cnt_d[i];
                shd_per_q[i] <= shd_per_d[i];
                act_per_q[i] <= act_per_d[i];
            end
            shd_mode_q <= shd_mode_d;
            act_mode_q <= act_mode_d;
            tick       <= tick_d;
            active     <= active_d;
            done       <= done_d;
        end
    end

endmodule

// File: tb/tb_multi_channel_timer.sv
// -----------------------------------------------------------------------------
// tb_multi_channel_timer
//
// Self-checking bench for multi_channel_timer (NUM_CH=4, WIDTH=26).
// Each scenario task drives one input vector per clock edge, pushes the
// {tick, active, done} value expected after that edge onto exp_q, then pops
// and compares once the edge has happened. Expected values are derived from
// the intended timing: start at edge 0 gives ticks after edges p, 2p, ...
// -----------------------------------------------------------------------------
module tb_multi_channel_timer;

    localparam int NUM_CH = 4;
    localparam int WIDTH  = 26;
    localparam int CH_W   = 2;
    localparam int OW     = 3 * NUM_CH;

    logic              clk = 1'b0;
    logic              reset;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [WIDTH-1:0]  cfg_period;
    logic              cfg_oneshot;
    logic [NUM_CH-1:0] start;
    logic [NUM_CH-1:0] stop;
    logic              pause;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] active;
    logic [NUM_CH-1:0] done;

    int checks   = 0;
    int failures = 0;
    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] exp_v;
    logic [OW-1:0] got_v;

    multi_channel_timer #(
        .NUM_CH (NUM_CH),
        .WIDTH  (WIDTH),
        .CH_W   (CH_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_period  (cfg_period),
        .cfg_oneshot (cfg_oneshot),
        .start       (start),
        .stop        (stop),
        .pause       (pause),
        .tick        (tick),
        .active      (active),
        .done        (done)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    // Advance one edge, then settle past it and clear one-shot strobes.
    task automatic step();
        @(posedge clk);
        #1;
        start  = '0;
        stop   = '0;
        cfg_we = 1'b0;
    endtask

    task automatic write_cfg(input int ch, input int p, input logic os);
        cfg_we      = 1'b1;
        cfg_ch      = CH_W'(ch);
        cfg_period  = WIDTH'(p);
        cfg_oneshot = os;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    function automatic logic [OW-1:0] pack(input logic [NUM_CH-1:0] t,
                                           input logic [NUM_CH-1:0] a,
                                           input logic [NUM_CH-1:0] d);
        return {t, a, d};
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            reset = (k == 0);
            if (k == 0) begin
                start = '1;
                write_cfg(1, 2, 1'b0);
            end
            exp_q.push_back('0);
            step();
            reset = 1'b0;
            got_v = {tick, active, done};
            exp_v = exp_q.pop_front();
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL reset k=%0d got=%h exp=%h", k, got_v, exp_v);
            end
        end
    endtask

    task automatic test_periodic();
        do_reset();
        write_cfg(0, 5, 1'b0);
        step();
        for (int k = 0; k <= 16; k++) begin
            if (k == 0) start[0] = 1'b1;
            exp_q.push_back(pack((k > 0 && k % 5 == 0) ? 4'b0001 : 4'b0000,
                                 4'b0001, 4'b0000));
            step();
            got_v = {tick, active, done};
            exp_v = exp_q.pop_front();
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL periodic k=%0d got=%h exp=%h", k, got_v, exp_v);
            end
        end
        stop[0] = 1'b1;
        exp_q.push_back('0);
        step();
        got_v = {tick, active, done};
        exp_v = exp_q.pop_front();
        checks++;
        if (got_v !== exp_v) begin
            failures++;
            $display("FAIL periodic_stop got=%h exp=%h", got_v, exp_v);
        end
    endtask

    task automatic test_oneshot();
        do_reset();
        write_cfg(2, 3, 1'b1);
        step();
        for (int k = 0; k <= 9; k++) begin
            if (k == 0) start[2] = 1'b1;
            if (k == 9) stop[2] = 1'b1;
            if (k == 9) exp_q.push_back('0);
            else exp_q.push_back(pack((k == 3) ? 4'b0100 : 4'b0000,
                                      (k < 3)  ? 4'b0100 : 4'b0000,
                                      (k >= 3) ? 4'b0100 : 4'b0000));
            step();
            got_v = {tick, active, done};
            exp_v = exp_q.pop_front();
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL oneshot k=%0d got=%h exp=%h", k, got_v, exp_v);
            end
        end
    endtask

    task automatic test_pause();
        do_reset();
        write_cfg(1, 4, 1'b0);
        step();
        for (int k = 0; k <= 15; k++) begin
            if (k == 0) start[1] = 1'b1;
            pause = (k == 6 || k == 7);
            exp_q.push_back(pack((k == 4 || k == 10 || k == 14) ? 4'b0010 : 4'b0000,
                                 4'b0010, 4'b0000));
            step();
            got_v = {tick, active, done};
            exp_v = exp_q.pop_front();
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL pause k=%0d got=%h exp=%h", k, got_v, exp_v);
            end
        end
        pause = 1'b0;
    endtask

    task automatic test_shadow_reload();
        do_reset();
        write_cfg(0, 8, 1'b0);
        step();
        for (int k = 0; k <= 15; k++) begin
            if (k == 0) start[0] = 1'b1;
            if (k == 3) write_cfg(0, 2, 1'b0);
            exp_q.push_back(pack((k == 8 || k == 10 || k == 12 || k == 14) ? 4'b0001 : 4'b0000,
                                 4'b0001, 4'b0000));
            step();
            got_v = {tick, active, done};
            exp_v = exp_q.pop_front();
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL reload k=%0d got=%h exp=%h", k, got_v, exp_v);
            end
        end
    endtask

    task automatic test_start_stop_period0();
        do_reset();
        write_cfg(3, 2, 1'b0);
        step();
        for (int k = 0; k <= 4; k++) begin
            if (k == 0) begin
                start[3] = 1'b1;
                stop[3]  = 1'b1;
            end
            exp_q.push_back('0);
            step();
            got_v = {tick, active, done};
            exp_v = exp_q.pop_front();
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL start_stop k=%0d got=%h exp=%h", k, got_v, exp_v);
            end
        end
        // Period 0 written on the same edge as start; pause blanks edges 6-7.
        for (int k = 0; k <= 9; k++) begin
            if (k == 0) begin
                write_cfg(3, 0, 1'b0);
                start[3] = 1'b1;
            end
            pause = (k == 6 || k == 7);
            if (k == 9) stop[3] = 1'b1;
            if (k == 9) exp_q.push_back('0);
            else exp_q.push_back(pack((k > 0 && k != 6 && k != 7) ? 4'b1000 : 4'b0000,
                                      4'b1000, 4'b0000));
            step();
            got_v = {tick, active, done};
            exp_v = exp_q.pop_front();
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL period0 k=%0d got=%h exp=%h", k, got_v, exp_v);
            end
        end
        pause = 1'b0;
    endtask

    task automatic test_multi_reset();
        do_reset();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            write_cfg(ch, 3, 1'b0);
            step();
        end
        for (int k = 0; k <= 12; k++) begin
            if (k == 0) start = '1;
            reset = (k == 9);
            if (k >= 9) exp_q.push_back('0);
            else exp_q.push_back(pack((k > 0 && k % 3 == 0) ? 4'b1111 : 4'b0000,
                                      4'b1111, 4'b0000));
            step();
            reset = 1'b0;
            got_v = {tick, active, done};
            exp_v = exp_q.pop_front();
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL multi_reset k=%0d got=%h exp=%h", k, got_v, exp_v);
            end
        end
        // Reset cleared the shadow periods to 0, which behaves as period 1.
        for (int k = 0; k <= 3; k++) begin
            if (k == 0) start = '1;
            exp_q.push_back(pack((k > 0) ? 4'b1111 : 4'b0000, 4'b1111, 4'b0000));
            step();
            got_v = {tick, active, done};
            exp_v = exp_q.pop_front();
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL post_reset k=%0d got=%h exp=%h", k, got_v, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        write_cfg(1, 4, 1'b0);
        step();
        for (int k = 0; k <= 11; k++) begin
            if (k == 0 || k == 2) start[1] = 1'b1;
            exp_q.push_back(pack((k == 6 || k == 10) ? 4'b0010 : 4'b0000,
                                 4'b0010, 4'b0000));
            step();
            got_v = {tick, active, done};
            exp_v = exp_q.pop_front();
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL back_to_back k=%0d got=%h exp=%h", k, got_v, exp_v);
            end
        end
    endtask

    task automatic test_random();
        int ch;
        int p;
        logic os;
        logic [NUM_CH-1:0] m;
        do_reset();
        for (int it = 0; it < 6; it++) begin
            ch = $urandom_range(0, NUM_CH - 1);
            p  = $urandom_range(1, 7);
            os = 1'($urandom_range(0, 1));
            m  = NUM_CH'(1 << ch);
            for (int k = 0; k <= 2 * p + 2; k++) begin
                if (k == 0) begin
                    write_cfg(ch, p, os);
                    start[ch] = 1'b1;
                end
                if (k == 2 * p + 2) begin
                    stop[ch] = 1'b1;
                    exp_q.push_back('0);
                end else if (os) begin
                    exp_q.push_back(pack((k == p) ? m : '0, (k < p) ? m : '0,
                                         (k >= p) ? m : '0));
                end else begin
                    exp_q.push_back(pack((k > 0 && k % p == 0) ? m : '0, m, '0));
                end
                step();
                got_v = {tick, active, done};
                exp_v = exp_q.pop_front();
                checks++;
                if (got_v !== exp_v) begin
                    failures++;
                    $display("FAIL random ch=%0d p=%0d os=%0d k=%0d got=%h exp=%h",
                             ch, p, os, k, got_v, exp_v);
                end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset       = 1'b1;
        cfg_we      = 1'b0;
        cfg_ch      = '0;
        cfg_period  = '0;
        cfg_oneshot = 1'b0;
        start       = '0;
        stop        = '0;
        pause       = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        test_reset();
        test_periodic();
        test_oneshot();
        test_pause();
        test_shadow_reload();
        test_start_stop_period0();
        test_multi_reset();
        test_back_to_back();
        test_random();

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
